// File: rtl/yutorina_ctrl_stage_if.sv
// Bundle between the MEM stage, register files and the control stage.
// The control stage is the slave side.
interface yutorina_ctrl_stage_if;
  logic        if_busy;
  logic        mem_busy;
  logic        mem_en_;
  logic [29:0] mem_pc;
  logic [4:0]  mem_w_addr;
  logic        mem_gpr_we_;
  logic [2:0]  mem_exp_code;
  logic [1:0]  mem_ctrl_op;
  logic [31:0] mem_out;
  logic        spr_we_;
  logic [4:0]  spr_w_addr;
  logic [31:0] spr_w_data;
  logic [4:0]  spr_r_addr;
  logic [7:0]  irq;
  logic        gpr_we_;
  logic [4:0]  gpr_w_addr;
  logic [31:0] gpr_w_data;
  logic [31:0] spr_r_data;
  logic        stall;
  logic        flush;
  logic [29:0] new_pc;
  logic        exe_mode;

  modport master (
    output if_busy, mem_busy, mem_en_, mem_pc, mem_w_addr, mem_gpr_we_,
           mem_exp_code, mem_ctrl_op, mem_out, spr_we_, spr_w_addr,
           spr_w_data, spr_r_addr, irq,
    input  gpr_we_, gpr_w_addr, gpr_w_data, spr_r_data, stall, flush,
           new_pc, exe_mode
  );

  modport slave (
    input  if_busy, mem_busy, mem_en_, mem_pc, mem_w_addr, mem_gpr_we_,
           mem_exp_code, mem_ctrl_op, mem_out, spr_we_, spr_w_addr,
           spr_w_data, spr_r_addr, irq,
    output gpr_we_, gpr_w_addr, gpr_w_data, spr_r_data, stall, flush,
           new_pc, exe_mode
  );
endinterface

// File: rtl/yutorina_ctrl_stage.sv
// Final pipeline stage: write-back commit, SPR file, exceptions, interrupts,
// exception return and global stall/flush/redirect generation.
module yutorina_ctrl_stage (
  input logic                  clk,
  input logic                  rst,
  yutorina_ctrl_stage_if.slave bus
);

  localparam logic [4:0] SPR_STATUS     = 5'd0;
  localparam logic [4:0] SPR_PRE_STATUS = 5'd1;
  localparam logic [4:0] SPR_EPC        = 5'd2;
  localparam logic [4:0] SPR_CAUSE      = 5'd3;
  localparam logic [4:0] SPR_IRQ_MASK   = 5'd4;
  localparam logic [4:0] SPR_VECTOR     = 5'd5;
  localparam logic [4:0] SPR_CYCLE      = 5'd6;

  localparam logic [2:0] EXP_NONE    = 3'd0;
  localparam logic [2:0] EXP_EXT_INT = 3'd1;
  localparam logic [1:0] OP_EXRT     = 2'd2;

  logic [1:0]  status;
  logic [1:0]  pre_status;
  logic [29:0] epc;
  logic [2:0]  cause;
  logic [7:0]  irq_mask;
  logic [29:0] vector;
  logic [31:0] cycle;

  logic       valid;
  logic       pending;
  logic       take_exp;
  logic       take_ret;
  logic       commit;
  logic       spr_wr;
  logic [2:0] exp_code;

  assign bus.stall = bus.if_busy | bus.mem_busy;
  assign valid     = ~bus.mem_en_ & ~bus.stall;
  assign pending   = status[0] & (|(bus.irq & ~irq_mask));
  assign take_exp  = valid & ((bus.mem_exp_code != EXP_NONE) | pending);
  assign exp_code  = (bus.mem_exp_code != EXP_NONE) ? bus.mem_exp_code : EXP_EXT_INT;
  assign take_ret  = valid & ~take_exp & (bus.mem_ctrl_op == OP_EXRT);
  assign commit    = valid & ~take_exp & ~take_ret;

  // A return owns STATUS..CAUSE this cycle; SPRs above CAUSE may still be written.
  assign spr_wr = valid & ~take_exp & ~bus.spr_we_ &
                  ~(take_ret & (bus.spr_w_addr <= SPR_CAUSE));

  assign bus.flush      = take_exp | take_ret;
  assign bus.gpr_we_    = commit ? bus.mem_gpr_we_ : 1'b1;
  assign bus.gpr_w_addr = bus.mem_w_addr;
  assign bus.gpr_w_data = bus.mem_out;
  assign bus.exe_mode   = status[1];

  always_comb begin
    bus.new_pc = 30'd0;
    if (take_exp)
      bus.new_pc = vector;
    else if (take_ret)
      bus.new_pc = epc;
  end

  always_comb begin
    bus.spr_r_data = 32'd0;
    case (bus.spr_r_addr)
      SPR_STATUS:     bus.spr_r_data = {30'd0, status};
      SPR_PRE_STATUS: bus.spr_r_data = {30'd0, pre_status};
      SPR_EPC:        bus.spr_r_data = {2'd0, epc};
      SPR_CAUSE:      bus.spr_r_data = {29'd0, cause};
      SPR_IRQ_MASK:   bus.spr_r_data = {24'd0, irq_mask};
      SPR_VECTOR:     bus.spr_r_data = {2'd0, vector};
      SPR_CYCLE:      bus.spr_r_data = cycle;
      default:        bus.spr_r_data = 32'd0;
    endcase
  end

  // Exception entry and SPR writes are mutually exclusive through spr_wr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status     <= 2'd0;
      pre_status <= 2'd0;
      epc        <= 30'd0;
      cause      <= 3'd0;
      irq_mask   <= 8'd0;
      vector     <= 30'd0;
      cycle      <= 32'd0;
    end else begin
      if (spr_wr && bus.spr_w_addr == SPR_CYCLE)
        cycle <= bus.spr_w_data;
      else
        cycle <= cycle + 32'd1;

      if (take_exp) begin
        epc        <= bus.mem_pc;
        cause      <= exp_code;
        pre_status <= status;
        status     <= 2'd0;
      end else begin
        if (take_ret)
          status <= pre_status;
        if (spr_wr) begin
          case (bus.spr_w_addr)
            SPR_STATUS:     status     <= bus.spr_w_data[1:0];
            SPR_PRE_STATUS: pre_status <= bus.spr_w_data[1:0];
            SPR_EPC:        epc        <= bus.spr_w_data[29:0];
            SPR_CAUSE:      cause      <= bus.spr_w_data[2:0];
            SPR_IRQ_MASK:   irq_mask   <= bus.spr_w_data[7:0];
            SPR_VECTOR:     vector     <= bus.spr_w_data[29:0];
            default:        ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_yutorina_ctrl_stage.sv
// Bench for yutorina_ctrl_stage: directed vector table, hand-written corner
// sequences, then random traffic against an SPR-array reference model.
module tb_yutorina_ctrl_stage;

  typedef struct {
    logic        if_busy;
    logic        mem_busy;
    logic        en_;
    logic [29:0] pc;
    logic [4:0]  w_addr;
    logic        gpr_we_;
    logic [31:0] out;
    logic [2:0]  exp;
    logic [1:0]  op;
    logic        spr_we_;
    logic [4:0]  spr_wa;
    logic [31:0] spr_wd;
    logic [4:0]  spr_ra;
    logic [7:0]  irq;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        e_gpr_we_;
    logic        e_flush;
    logic [29:0] e_new_pc;
    logic [31:0] e_spr;
  } vec_t;

  typedef enum {K_IDLE, K_EXC, K_RET, K_COMMIT} kind_t;

  localparam logic [31:0] SPR_MASK [7] = '{32'h3, 32'h3, 32'h3FFF_FFFF, 32'h7,
                                           32'hFF, 32'h3FFF_FFFF, 32'hFFFF_FFFF};

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  yutorina_ctrl_stage_if bus();
  yutorina_ctrl_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  logic [31:0] spr_m [7];
  stim_t       cur;
  kind_t       kind;
  logic [2:0]  e_code;
  logic        e_stall, e_flush, e_gpr_we_, e_exe;
  logic [29:0] e_new_pc;
  logic [31:0] e_spr;

  function automatic stim_t st(logic en_, logic [29:0] pc, logic [4:0] w_addr,
                               logic gpr_we_, logic [31:0] out, logic [2:0] exp,
                               logic [1:0] op, logic spr_we_, logic [4:0] spr_wa,
                               logic [31:0] spr_wd, logic [4:0] spr_ra, logic [7:0] irq);
    stim_t s;
    s.if_busy = 1'b0; s.mem_busy = 1'b0; s.en_ = en_; s.pc = pc;
    s.w_addr = w_addr; s.gpr_we_ = gpr_we_; s.out = out; s.exp = exp; s.op = op;
    s.spr_we_ = spr_we_; s.spr_wa = spr_wa; s.spr_wd = spr_wd;
    s.spr_ra = spr_ra; s.irq = irq;
    return s;
  endfunction

  function automatic stim_t bub(logic [4:0] ra);
    return st(1'b1, 30'd0, 5'd0, 1'b1, 32'd0, 3'd0, 2'd0, 1'b1, 5'd0, 32'd0, ra, 8'd0);
  endfunction

  function automatic stim_t ssr(logic [4:0] wa, logic [31:0] wd);
    return st(1'b0, 30'd0, 5'd0, 1'b1, 32'd0, 3'd0, 2'd1, 1'b0, wa, wd, 5'd0, 8'd0);
  endfunction

  function automatic logic [31:0] spr_read(logic [4:0] a);
    int idx;
    idx = int'(a);
    return (idx < 7) ? spr_m[idx] : 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 7; i++) spr_m[i] = 32'd0;
  endtask

  task automatic model_eval();
    e_stall = cur.if_busy | cur.mem_busy;
    kind = K_IDLE;
    e_code = 3'd0;
    if (!cur.en_ && !e_stall) begin
      if (cur.exp != 3'd0) begin
        kind = K_EXC; e_code = cur.exp;
      end else if (spr_m[0][0] && ((cur.irq & ~spr_m[4][7:0]) != 8'd0)) begin
        kind = K_EXC; e_code = 3'd1;
      end else if (cur.op == 2'd2) begin
        kind = K_RET;
      end else begin
        kind = K_COMMIT;
      end
    end
    e_flush   = (kind == K_EXC) || (kind == K_RET);
    e_new_pc  = (kind == K_EXC) ? spr_m[5][29:0] : (kind == K_RET) ? spr_m[2][29:0] : 30'd0;
    e_gpr_we_ = (kind == K_COMMIT) ? cur.gpr_we_ : 1'b1;
    e_spr     = spr_read(cur.spr_ra);
    e_exe     = spr_m[0][1];
  endtask

  task automatic model_edge();
    logic [31:0] nxt [7];
    int wa;
    for (int i = 0; i < 7; i++) nxt[i] = spr_m[i];
    nxt[6] = spr_m[6] + 32'd1;
    wa = int'(cur.spr_wa);
    case (kind)
      K_EXC: begin
        nxt[2] = {2'b00, cur.pc};
        nxt[3] = {29'd0, e_code};
        nxt[1] = spr_m[0];
        nxt[0] = 32'd0;
      end
      K_RET: begin
        nxt[0] = spr_m[1];
        if (!cur.spr_we_ && wa >= 4 && wa < 7) nxt[wa] = cur.spr_wd & SPR_MASK[wa];
      end
      K_COMMIT: begin
        if (!cur.spr_we_ && wa < 7) nxt[wa] = cur.spr_wd & SPR_MASK[wa];
      end
      default: ;
    endcase
    for (int i = 0; i < 7; i++) spr_m[i] = nxt[i];
  endtask

  task automatic apply_stimulus(stim_t s);
    bus.if_busy = s.if_busy;       bus.mem_busy = s.mem_busy;
    bus.mem_en_ = s.en_;           bus.mem_pc = s.pc;
    bus.mem_w_addr = s.w_addr;     bus.mem_gpr_we_ = s.gpr_we_;
    bus.mem_out = s.out;           bus.mem_exp_code = s.exp;
    bus.mem_ctrl_op = s.op;        bus.spr_we_ = s.spr_we_;
    bus.spr_w_addr = s.spr_wa;     bus.spr_w_data = s.spr_wd;
    bus.spr_r_addr = s.spr_ra;     bus.irq = s.irq;
  endtask

  task automatic check_output(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(stim_t s);
    @(negedge clk);
    cur = s;
    apply_stimulus(s);
    #1;
    model_eval();
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
  endtask

  task automatic check_model();
    check_output("rnd_stall", {31'd0, bus.stall}, {31'd0, e_stall});
    check_output("rnd_flush", {31'd0, bus.flush}, {31'd0, e_flush});
    check_output("rnd_gpr_we", {31'd0, bus.gpr_we_}, {31'd0, e_gpr_we_});
    if (e_flush) check_output("rnd_new_pc", {2'd0, bus.new_pc}, {2'd0, e_new_pc});
    if (!e_gpr_we_) begin
      check_output("rnd_gpr_addr", {27'd0, bus.gpr_w_addr}, {27'd0, cur.w_addr});
      check_output("rnd_gpr_data", bus.gpr_w_data, cur.out);
    end
    check_output("rnd_spr_r", bus.spr_r_data, e_spr);
    check_output("rnd_exe_mode", {31'd0, bus.exe_mode}, {31'd0, e_exe});
  endtask

  task automatic release_reset();
    @(negedge clk);
    cur = bub(5'd0);
    apply_stimulus(cur);
    rst = 1'b1;
    model_eval();
    edge_step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t  vt [8];
    stim_t s;

    vt[0] = '{st(1'b0, 30'h10, 5'd3, 1'b0, 32'h1234, 3'd0, 2'd0, 1'b1, 5'd0, 32'd0, 5'd0, 8'd0), 1'b0, 1'b0, 30'd0, 32'd0};
    vt[1] = '{st(1'b0, 30'h11, 5'd4, 1'b1, 32'h0, 3'd0, 2'd1, 1'b0, 5'd5, 32'h40, 5'd5, 8'd0), 1'b1, 1'b0, 30'd0, 32'd0};
    vt[2] = '{st(1'b0, 30'h12, 5'd0, 1'b1, 32'h0, 3'd0, 2'd1, 1'b0, 5'd0, 32'h3, 5'd5, 8'd0), 1'b1, 1'b0, 30'd0, 32'h40};
    vt[3] = '{st(1'b0, 30'h100, 5'd7, 1'b0, 32'hDEAD, 3'd3, 2'd0, 1'b1, 5'd0, 32'd0, 5'd0, 8'd0), 1'b1, 1'b1, 30'h40, 32'h3};
    vt[4] = '{bub(5'd2), 1'b1, 1'b0, 30'd0, 32'h100};
    vt[5] = '{bub(5'd3), 1'b1, 1'b0, 30'd0, 32'h3};
    vt[6] = '{bub(5'd1), 1'b1, 1'b0, 30'd0, 32'h3};
    vt[7] = '{bub(5'd0), 1'b1, 1'b0, 30'd0, 32'h0};

    model_reset();
    cur = bub(5'd6);
    apply_stimulus(cur);
    #3;
    check_output("rst_gpr_we", {31'd0, bus.gpr_we_}, 32'd1);
    check_output("rst_flush", {31'd0, bus.flush}, 32'd0);
    check_output("rst_new_pc", {2'd0, bus.new_pc}, 32'd0);
    check_output("rst_exe_mode", {31'd0, bus.exe_mode}, 32'd0);
    check_output("rst_cycle", bus.spr_r_data, 32'd0);
    #20;
    release_reset();

    for (int i = 0; i < 8; i++) begin
      drive(vt[i].s);
      check_output($sformatf("tbl%0d_gpr_we", i), {31'd0, bus.gpr_we_}, {31'd0, vt[i].e_gpr_we_});
      check_output($sformatf("tbl%0d_flush", i), {31'd0, bus.flush}, {31'd0, vt[i].e_flush});
      if (vt[i].e_flush)
        check_output($sformatf("tbl%0d_new_pc", i), {2'd0, bus.new_pc}, {2'd0, vt[i].e_new_pc});
      if (!vt[i].e_gpr_we_) begin
        check_output($sformatf("tbl%0d_gpr_addr", i), {27'd0, bus.gpr_w_addr}, {27'd0, vt[i].s.w_addr});
        check_output($sformatf("tbl%0d_gpr_data", i), bus.gpr_w_data, vt[i].s.out);
      end
      check_output($sformatf("tbl%0d_spr_r", i), bus.spr_r_data, vt[i].e_spr);
      edge_step();
    end

    // exception return
    drive(ssr(5'd2, 32'h101)); edge_step();
    drive(ssr(5'd1, 32'h3));   edge_step();
    drive(st(1'b0, 30'h150, 5'd9, 1'b0, 32'h55, 3'd0, 2'd2, 1'b1, 5'd0, 32'd0, 5'd0, 8'd0));
    check_output("ret_flush", {31'd0, bus.flush}, 32'd1);
    check_output("ret_new_pc", {2'd0, bus.new_pc}, 32'h101);
    check_output("ret_gpr_we", {31'd0, bus.gpr_we_}, 32'd1);
    edge_step();
    drive(bub(5'd0));
    check_output("ret_status", bus.spr_r_data, 32'h3);
    check_output("ret_exe_mode", {31'd0, bus.exe_mode}, 32'd1);
    edge_step();

    // interrupt held off by stall, then taken with its SPR write dropped
    drive(ssr(5'd4, 32'hFE)); edge_step();
    drive(ssr(5'd0, 32'h1));  edge_step();
    for (int i = 0; i < 3; i++) begin
      s = st(1'b0, 30'h200, 5'd1, 1'b0, 32'h1, 3'd0, 2'd0, 1'b1, 5'd0, 32'd0, 5'd0, 8'h01);
      s.if_busy = 1'b1;
      drive(s);
      check_output("stall_stall", {31'd0, bus.stall}, 32'd1);
      check_output("stall_flush", {31'd0, bus.flush}, 32'd0);
      check_output("stall_gpr_we", {31'd0, bus.gpr_we_}, 32'd1);
      edge_step();
    end
    drive(st(1'b0, 30'h200, 5'd1, 1'b0, 32'h1, 3'd0, 2'd0, 1'b0, 5'd4, 32'd0, 5'd0, 8'h01));
    check_output("irq_flush", {31'd0, bus.flush}, 32'd1);
    check_output("irq_new_pc", {2'd0, bus.new_pc}, 32'h40);
    check_output("irq_gpr_we", {31'd0, bus.gpr_we_}, 32'd1);
    edge_step();
    drive(bub(5'd2)); check_output("irq_epc", bus.spr_r_data, 32'h200); edge_step();
    drive(bub(5'd3)); check_output("irq_cause", bus.spr_r_data, 32'h1); edge_step();
    drive(bub(5'd4)); check_output("irq_mask_kept", bus.spr_r_data, 32'hFE); edge_step();
    drive(bub(5'd0)); check_output("irq_status", bus.spr_r_data, 32'h0); edge_step();
    drive(ssr(5'd0, 32'h1)); edge_step();
    drive(st(1'b0, 30'h210, 5'd2, 1'b0, 32'h2, 3'd0, 2'd0, 1'b1, 5'd0, 32'd0, 5'd0, 8'h02));
    check_output("masked_flush", {31'd0, bus.flush}, 32'd0);
    check_output("masked_gpr_we", {31'd0, bus.gpr_we_}, 32'd0);
    edge_step();

    // interrupt during a bubble waits for the next valid instruction
    drive(st(1'b1, 30'h0, 5'd0, 1'b1, 32'h0, 3'd0, 2'd0, 1'b1, 5'd0, 32'd0, 5'd0, 8'h01));
    check_output("defer_flush", {31'd0, bus.flush}, 32'd0);
    edge_step();
    drive(st(1'b0, 30'h280, 5'd0, 1'b1, 32'h0, 3'd0, 2'd0, 1'b1, 5'd0, 32'd0, 5'd0, 8'h01));
    check_output("defer_taken", {31'd0, bus.flush}, 32'd1);
    check_output("defer_new_pc", {2'd0, bus.new_pc}, 32'h40);
    edge_step();
    drive(bub(5'd2)); check_output("defer_epc", bus.spr_r_data, 32'h280); edge_step();

    // SSR to STATUS loses against a simultaneous exception
    drive(ssr(5'd0, 32'h2)); edge_step();
    drive(st(1'b0, 30'h300, 5'd0, 1'b1, 32'h0, 3'd4, 2'd1, 1'b0, 5'd0, 32'h3, 5'd0, 8'd0));
    check_output("ssrexc_flush", {31'd0, bus.flush}, 32'd1);
    edge_step();
    drive(bub(5'd0)); check_output("ssrexc_status", bus.spr_r_data, 32'h0); edge_step();
    drive(bub(5'd3)); check_output("ssrexc_cause", bus.spr_r_data, 32'h4); edge_step();
    drive(bub(5'd1)); check_output("ssrexc_pre", bus.spr_r_data, 32'h2); edge_step();

    // CYCLE wrap
    drive(ssr(5'd6, 32'hFFFF_FFFE)); edge_step();
    drive(bub(5'd6)); check_output("cyc_written", bus.spr_r_data, 32'hFFFF_FFFE); edge_step();
    drive(bub(5'd6)); check_output("cyc_max", bus.spr_r_data, 32'hFFFF_FFFF); edge_step();
    drive(bub(5'd6)); check_output("cyc_wrap", bus.spr_r_data, 32'h0); edge_step();

    // asynchronous reset while a flush is pending
    drive(ssr(5'd0, 32'h2)); edge_step();
    drive(st(1'b0, 30'h321, 5'd0, 1'b1, 32'h0, 3'd6, 2'd0, 1'b1, 5'd0, 32'd0, 5'd0, 8'd0));
    check_output("rstf_flush", {31'd0, bus.flush}, 32'd1);
    check_output("rstf_exe_before", {31'd0, bus.exe_mode}, 32'd1);
    rst = 1'b0;
    #1;
    check_output("rstf_status", bus.spr_r_data, 32'h0);
    check_output("rstf_exe_after", {31'd0, bus.exe_mode}, 32'd0);
    check_output("rstf_new_pc", {2'd0, bus.new_pc}, 32'd0);
    bus.mem_en_ = 1'b1;
    #1;
    check_output("rstf_flush_drop", {31'd0, bus.flush}, 32'd0);
    check_output("rstf_gpr_we", {31'd0, bus.gpr_we_}, 32'd1);
    model_reset();
    @(posedge clk);
    release_reset();

    for (int i = 0; i < 400; i++) begin
      s.if_busy  = ($urandom_range(0, 4) == 0);
      s.mem_busy = ($urandom_range(0, 4) == 0);
      s.en_      = ($urandom_range(0, 3) == 0);
      s.pc       = 30'($urandom);
      s.w_addr   = 5'($urandom);
      s.gpr_we_  = 1'($urandom);
      s.out      = $urandom;
      s.exp      = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      s.op       = 2'($urandom);
      s.spr_we_  = ($urandom_range(0, 2) != 0) || (s.op == 2'd2);
      s.spr_wa   = 5'($urandom_range(0, 8));
      s.spr_wd   = $urandom;
      s.spr_ra   = 5'($urandom_range(0, 9));
      s.irq      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0;
      drive(s);
      check_model();
      edge_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/yutorina_ctrl_stage.md
# yutorina_ctrl_stage

Final pipeline stage: consumes the MEM-stage output register, commits GPR write-back, owns the special-purpose registers (SPRs), takes exceptions and external interrupts, executes exception return, and produces the global stall/flush/new-PC controls for every stage. All architectural state changes of a retiring instruction happen at the clock edge at which it leaves MEM.

## Interface
No parameters. Words are 32 bit, word addresses 30 bit, GPR/SPR addresses 5 bit, exception codes 3 bit, ctrl ops 2 bit.
- clk  in  1  stage clock
- rst  in  1  reset, asynchronous, active-low
- if_busy  in  1  fetch bus interface busy
- mem_busy  in  1  MEM bus interface busy
- mem_en_  in  1  MEM output valid (active-low)
- mem_pc  in  30  word address of the MEM instruction
- mem_w_addr  in  5  destination GPR
- mem_gpr_we_  in  1  GPR write request (active-low)
- mem_exp_code  in  3  0 NONE, 1 EXT_INT, 2 UNDEF, 3 OVERFLOW, 4 LOAD_MISS_ALIGN, 5 STORE_MISS_ALIGN, 6 TRAP, 7 PRV_VIO
- mem_ctrl_op  in  2  0 NONE, 1 SSR, 2 EXRT, 3 reserved (treated as NONE)
- mem_out  in  32  result to write back
- spr_we_, spr_w_addr, spr_w_data  in  1/5/32  SPR write from MEM (active-low enable)
- spr_r_addr  in  5  SPR read address from ID
- irq  in  8  level-sensitive external interrupt lines
- gpr_we_, gpr_w_addr, gpr_w_data  out  1/5/32  register-file write port
- spr_r_data  out  32  combinational SPR read data
- stall  out  1  global stall
- flush  out  1  global flush
- new_pc  out  30  redirect target, valid when flush=1
- exe_mode  out  1  STATUS.USER, to ID for privilege checks

## Operation
- SPR map: 0 STATUS {bit1 USER, bit0 IE}; 1 PRE_STATUS; 2 EPC (30 b, bits 31:30 read 0); 3 CAUSE (3 b); 4 IRQ_MASK (8 b, 1 = masked); 5 VECTOR (30 b); 6 CYCLE (32 b). Unimplemented addresses read 0, writes ignored. Unused high bits read 0.
- valid = (mem_en_==0) and stall==0.
- stall = if_busy | mem_busy (combinational).
- pending = STATUS.IE & |(irq & ~IRQ_MASK).
- Priority in a valid cycle: (1) mem_exp_code≠NONE → exception with that code; (2) else pending → exception, code EXT_INT; (3) else mem_ctrl_op==EXRT → return; (4) else normal commit.
- Exception taken: flush=1, new_pc=VECTOR; at edge EPC←mem_pc, CAUSE←code, PRE_STATUS←STATUS, STATUS←{USER=0, IE=0}. GPR and SPR writes of that instruction suppressed.
- Return: flush=1, new_pc=EPC; at edge STATUS←PRE_STATUS; GPR write suppressed.
- Normal commit: gpr_we_=mem_gpr_we_, address/data passed through combinationally; SPR write applied at edge if spr_we_==0.
- Not valid: gpr_we_=1, flush=0, no SPR update other than CYCLE.
- SPR write to STATUS/PRE_STATUS/EPC/CAUSE in the same cycle as an exception or return: exception/return update wins.
- CYCLE: +1 every edge including stalls, wraps 0xFFFFFFFF→0; a committed SPR write to CYCLE wins over increment.
- spr_r_data reflects register state only (no bypass of same-cycle writes).

## Timing
- Reset (rst=0, asynchronous): all SPRs 0 (IE=0, kernel mode, VECTOR=0, CYCLE=0). Outputs then: gpr_we_=1, flush=0, new_pc=0, exe_mode=0; stall follows inputs.
- stall, flush, new_pc, gpr_* are combinational from current inputs/SPRs; SPR updates take effect at the next rising edge, visible on spr_r_data/exe_mode the cycle after.
- flush is asserted for exactly the cycle the causing instruction sits in MEM; since that instruction is replaced by a bubble at the edge, flush never holds a second cycle without a new cause.
- Stall has priority: while stall=1 no exception, interrupt or return is taken; they are evaluated once stall drops.
- Interrupt asserted while mem_en_=1 (bubble) is deferred to the next valid cycle.
- Reset mid-flush: state clears immediately; flush drops with mem_en_ reset.

## Test plan
- Reset then commit mem_en_=0, w_addr=3, we_=0, out=0x1234 → gpr_we_=0, addr 3, data 0x1234, flush=0.
- mem_exp_code=OVERFLOW, mem_pc=0x100, VECTOR=0x40, STATUS=0b11 → flush=1, new_pc=0x40, gpr_we_=1; next cycle EPC=0x100, CAUSE=3, PRE_STATUS=0b11, STATUS=0.
- EXRT with EPC=0x101, PRE_STATUS=0b11 → flush=1, new_pc=0x101; next cycle STATUS=0b11, exe_mode=1.
- IE=1, IRQ_MASK=0xFE, irq=0x01 with stall=1 for 3 cycles → no flush; stall drops → EXT_INT taken, EPC=mem_pc, SPR write in same cycle suppressed; irq=0x02 only → no interrupt.
- SSR to STATUS simultaneous with LOAD_MISS_ALIGN → STATUS=0, CAUSE=4.
- CYCLE written 0xFFFFFFFE → reads 0xFFFFFFFF then 0x00000000.
